mem_initiator: RTL and testbench

Bus initiator for the register-file memory interface. It accepts access commands over a valid/ready stream, buffers them in a small FIFO, and drives the single-cycle `mem_*` port of a register file (ena/addr/wena/wdata out, rdata/err in). Each access returns one response with the read data and error flag. It sits between a firmware/test sequencer or debug bridge and one register-file instance.

---
 rtl/mem_initiator.sv | 257 +++++++++++++++++++++++++
 tb/tb_mem_initiator.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_initiator.sv
// -----------------------------------------------------------------------------
// mem_initiator
//   Bus initiator for a register-file memory port. Access commands arrive on a
//   valid/ready stream and are buffered in a small first-word-fall-through FIFO.
//   They are then issued one at a time as single-cycle accesses on the mem_*
//   port. Every access returns one response holding the read data and the
//   error flag.
//
//   Optional feature (macro MEM_INITIATOR_RDBACK_EN):
//     A write that completes without error is followed by one readback cycle
//     (VERIFY). The response then carries the readback data, the error flag
//     of the VERIFY cycle, and a mismatch flag (readback != written data).
//     Without the macro there is no VERIFY state and rsp_mism_o is tied to 0.
//
//   Ports:
//     main_clk_i / main_rst_an_i : clock, async reset (active HIGH despite name)
//     cmd_*                      : command stream in (addr, wena, wdata)
//     rsp_*                      : response stream out (rdata, err, mism)
//     mem_*                      : single-cycle register-file bus
//     busy_o                     : work queued, in progress or undelivered
//     err_clr_i / err_cnt_o      : saturating bus-error counter and its clear
// -----------------------------------------------------------------------------
module mem_initiator #(
   parameter int ADDR_W     = 13,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              main_clk_i,
   input  logic              main_rst_an_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic              cmd_wena_i,
   input  logic [DATA_W-1:0] cmd_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              rsp_mism_o,
   output logic              mem_ena_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_wena_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_err_i,
   output logic              busy_o,
   input  logic              err_clr_i,
   output logic [7:0]        err_cnt_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              wena;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

`ifdef MEM_INITIATOR_RDBACK_EN
   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, VERIFY = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1} state_t;
`endif

   // ---------------------------------------------------------------------------
   // Command FIFO. Pointers carry one extra wrap bit to tell full from empty.
   // ---------------------------------------------------------------------------
   cmd_t             fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
   logic             fifo_empty, fifo_full;
   logic             push, pop;
   logic             rdy_en_q;
   cmd_t             head;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   // rdy_en_q keeps cmd_ready_o low while reset is asserted; it never looks at
   // cmd_valid_i, so there is no combinational valid->ready path.
   assign cmd_ready_o = rdy_en_q && !fifo_full;
   assign push        = cmd_valid_i && cmd_ready_o;
   assign head        = fifo_mem[rd_ptr_q[PTR_W-1:0]];

   always_ff @(posedge main_clk_i) begin
      if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= '{addr: cmd_addr_i, wena: cmd_wena_i, wdata: cmd_wdata_i};
   end

   always_ff @(posedge main_clk_i or posedge main_rst_an_i) begin
      if (main_rst_an_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         rdy_en_q <= 1'b0;
      end else begin
         rdy_en_q <= 1'b1;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Access FSM and registered bus outputs
   // ---------------------------------------------------------------------------
   state_t            state_q, state_d;
   logic              mem_ena_q, mem_ena_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_wena_q, mem_wena_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              rsp_err_q;
   logic              rsp_mism_q;

   logic              rsp_cap;
   logic [DATA_W-1:0] cap_rdata;
   logic              cap_err;
   logic              cap_mism;
   logic              acc_cycle;

`ifdef MEM_INITIATOR_RDBACK_EN
   // mem_wdata_o is cleared during VERIFY, so keep the written word for compare
   logic [DATA_W-1:0] wsav_q;

   always_ff @(posedge main_clk_i or posedge main_rst_an_i) begin
      if (main_rst_an_i)                   wsav_q <= '0;
      else if (state_q == ACCESS)          wsav_q <= mem_wdata_q;
   end
`endif

   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      mem_ena_d   = mem_ena_q;
      mem_addr_d  = mem_addr_q;
      mem_wena_d  = mem_wena_q;
      mem_wdata_d = mem_wdata_q;
      rsp_cap     = 1'b0;
      cap_rdata   = '0;
      cap_err     = 1'b0;
      cap_mism    = 1'b0;
      case (state_q)
         IDLE: begin
            // Only start when the response slot will be free by the time the
            // access completes; otherwise the bus stays idle and the command
            // waits in the FIFO.
            if (!fifo_empty && (!rsp_valid_q || rsp_ready_i)) begin
               pop         = 1'b1;
               state_d     = ACCESS;
               mem_ena_d   = 1'b1;
               mem_addr_d  = head.addr;
               mem_wena_d  = head.wena;
               mem_wdata_d = head.wdata;
            end
         end
         ACCESS: begin
            state_d     = IDLE;
            mem_ena_d   = 1'b0;
            mem_wena_d  = 1'b0;
            mem_wdata_d = '0;
            rsp_cap     = 1'b1;
            cap_rdata   = mem_wena_q ? '0 : mem_rdata_i;
            cap_err     = mem_err_i;
`ifdef MEM_INITIATOR_RDBACK_EN
            // Clean write: read the same address back before responding.
            if (mem_wena_q && !mem_err_i) begin
               state_d   = VERIFY;
               mem_ena_d = 1'b1;
               rsp_cap   = 1'b0;
            end
`endif
         end
`ifdef MEM_INITIATOR_RDBACK_EN
         VERIFY: begin
            state_d   = IDLE;
            mem_ena_d = 1'b0;
            rsp_cap   = 1'b1;
            cap_rdata = mem_rdata_i;
            cap_err   = mem_err_i;
            cap_mism  = (mem_rdata_i != wsav_q);
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge main_clk_i or posedge main_rst_an_i) begin
      if (main_rst_an_i) begin
         state_q     <= IDLE;
         mem_ena_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wena_q  <= 1'b0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_ena_q   <= mem_ena_d;
         mem_addr_q  <= mem_addr_d;
         mem_wena_q  <= mem_wena_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Response slot. A capture only happens when the slot was freed on the way
   // into ACCESS, so it never overwrites an undelivered response.
   // ---------------------------------------------------------------------------
   always_ff @(posedge main_clk_i or posedge main_rst_an_i) begin
      if (main_rst_an_i) begin
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_mism_q  <= 1'b0;
      end else if (rsp_cap) begin
         rsp_valid_q <= 1'b1;
         rsp_rdata_q <= cap_rdata;
         rsp_err_q   <= cap_err;
         rsp_mism_q  <= cap_mism;
      end else if (rsp_ready_i) begin
         rsp_valid_q <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Saturating bus-error counter; clear has priority over increment.
   // ---------------------------------------------------------------------------
   logic [7:0] err_cnt_q;

`ifdef MEM_INITIATOR_RDBACK_EN
   assign acc_cycle = (state_q == ACCESS) || (state_q == VERIFY);
`else
   assign acc_cycle = (state_q == ACCESS);
`endif

   always_ff @(posedge main_clk_i or posedge main_rst_an_i) begin
      if (main_rst_an_i)                                    err_cnt_q <= '0;
      else if (err_clr_i)                                   err_cnt_q <= '0;
      else if (acc_cycle && mem_err_i && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign mem_ena_o   = mem_ena_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wena_o  = mem_wena_q;
   assign mem_wdata_o = mem_wdata_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
`ifdef MEM_INITIATOR_RDBACK_EN
   assign rsp_mism_o  = rsp_mism_q;
`else
   assign rsp_mism_o  = 1'b0;
`endif
   assign err_cnt_o   = err_cnt_q;
   assign busy_o      = !fifo_empty || (state_q != IDLE) || rsp_valid_q;

endmodule

// File: tb/tb_mem_initiator.sv
// -----------------------------------------------------------------------------
// tb_mem_initiator
//   Directed bench for mem_initiator. A behavioural responder answers the bus:
//   read data is either an override value or BEEF_<addr>, and address 0x1FFC
//   flags a bus error whenever it is accessed.
// -----------------------------------------------------------------------------
module tb_mem_initiator;

   logic        clk;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [12:0] cmd_addr;
   logic        cmd_wena;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err, rsp_mism;
   logic        mem_ena;
   logic [12:0] mem_addr;
   logic        mem_wena;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_err;
   logic        busy;
   logic        err_clr;
   logic [7:0]  err_cnt;

   logic        ovr_en;
   logic [31:0] ovr_val;

   int n_cmp = 0;
   int n_err = 0;

   mem_initiator dut (
      .main_clk_i    (clk),
      .main_rst_an_i (rst),
      .cmd_valid_i   (cmd_valid),
      .cmd_ready_o   (cmd_ready),
      .cmd_addr_i    (cmd_addr),
      .cmd_wena_i    (cmd_wena),
      .cmd_wdata_i   (cmd_wdata),
      .rsp_valid_o   (rsp_valid),
      .rsp_ready_i   (rsp_ready),
      .rsp_rdata_o   (rsp_rdata),
      .rsp_err_o     (rsp_err),
      .rsp_mism_o    (rsp_mism),
      .mem_ena_o     (mem_ena),
      .mem_addr_o    (mem_addr),
      .mem_wena_o    (mem_wena),
      .mem_wdata_o   (mem_wdata),
      .mem_rdata_i   (mem_rdata),
      .mem_err_i     (mem_err),
      .busy_o        (busy),
      .err_clr_i     (err_clr),
      .err_cnt_o     (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // responder
   assign mem_rdata = ovr_en ? ovr_val : {16'hBEEF, 3'b000, mem_addr};
   assign mem_err   = mem_ena && (mem_addr == 13'h1FFC);

   function automatic logic [31:0] exp_rd(input logic [12:0] a);
      return {16'hBEEF, 3'b000, a};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // step to 1 time unit past the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one-cycle command push; returns in the cycle after acceptance
   task automatic send(input logic [12:0] a, input logic w, input logic [31:0] d);
      int b = 0;
      while (!cmd_ready && b < 50) begin
         tick();
         b++;
      end
      chk("send_rdy", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_wena  = w;
      cmd_wdata = d;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      int k, b;
      logic seen;
      logic [31:0] exq [5];

      rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_wena = 1'b0; cmd_wdata = '0;
      rsp_ready = 1'b1; err_clr = 1'b0; ovr_en = 1'b0; ovr_val = '0;

      // ---- reset values while asserted
      #2;
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_mem_ena",   {31'd0, mem_ena},   32'd0);
      chk("rst_mem_addr",  {19'd0, mem_addr},  32'd0);
      chk("rst_busy",      {31'd0, busy},      32'd0);
      chk("rst_err_cnt",   {24'd0, err_cnt},   32'd0);
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

      // ---- T1: read 0x0004, responder returns 0xA5
      ovr_en = 1'b1; ovr_val = 32'h0000_00A5;
      send(13'h0004, 1'b0, 32'd0);                        // cycle N+1
      chk("t1_n1_ena",   {31'd0, mem_ena},   32'd0);
      tick();                                             // N+2
      chk("t1_ena",      {31'd0, mem_ena},   32'd1);
      chk("t1_wena",     {31'd0, mem_wena},  32'd0);
      chk("t1_addr",     {19'd0, mem_addr},  32'h4);
      chk("t1_n2_rsp",   {31'd0, rsp_valid}, 32'd0);
      tick();                                             // N+3
      chk("t1_rsp_vld",  {31'd0, rsp_valid}, 32'd1);
      chk("t1_rdata",    rsp_rdata,          32'h0000_00A5);
      chk("t1_err",      {31'd0, rsp_err},   32'd0);
      chk("t1_ena_off",  {31'd0, mem_ena},   32'd0);
      tick();
      chk("t1_rsp_done", {31'd0, rsp_valid}, 32'd0);
      chk("t1_idle",     {31'd0, busy},      32'd0);

      // ---- T2: write 0x12345678 to 0x0000
      ovr_val = 32'h0000_0078;
      send(13'h0000, 1'b1, 32'h1234_5678);
      tick();                                             // N+2
      chk("t2_ena",      {31'd0, mem_ena},   32'd1);
      chk("t2_wena",     {31'd0, mem_wena},  32'd1);
      chk("t2_wdata",    mem_wdata,          32'h1234_5678);
      chk("t2_addr",     {19'd0, mem_addr},  32'h0);
      tick();                                             // N+3
`ifdef MEM_INITIATOR_RDBACK_EN
      chk("t2_vfy_ena",  {31'd0, mem_ena},   32'd1);
      chk("t2_vfy_wena", {31'd0, mem_wena},  32'd0);
      chk("t2_vfy_addr", {19'd0, mem_addr},  32'h0);
      chk("t2_vfy_rsp",  {31'd0, rsp_valid}, 32'd0);
      tick();                                             // N+4
      chk("t2_rsp_vld",  {31'd0, rsp_valid}, 32'd1);
      chk("t2_rdata",    rsp_rdata,          32'h0000_0078);
      chk("t2_err",      {31'd0, rsp_err},   32'd0);
      chk("t2_mism",     {31'd0, rsp_mism},  32'd1);
`else
      chk("t2_rsp_vld",  {31'd0, rsp_valid}, 32'd1);
      chk("t2_rdata",    rsp_rdata,          32'd0);
      chk("t2_err",      {31'd0, rsp_err},   32'd0);
      chk("t2_mism",     {31'd0, rsp_mism},  32'd0);
      chk("t2_ena_off",  {31'd0, mem_ena},   32'd0);
      chk("t2_wena_off", {31'd0, mem_wena},  32'd0);
      chk("t2_wdata_off", mem_wdata,         32'd0);
`endif
      tick();
      ovr_en = 1'b0;

      // ---- T3: five reads with response stalled
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exq[i] = exp_rd(13'h0010 + 13'(4 * i));
         send(13'h0010 + 13'(4 * i), 1'b0, 32'd0);
      end
      chk("t3_full",     {31'd0, cmd_ready}, 32'd0);
      chk("t3_rsp_vld",  {31'd0, rsp_valid}, 32'd1);
      tick(); tick(); tick();
      chk("t3_bus_idle", {31'd0, mem_ena},   32'd0);
      chk("t3_still_full", {31'd0, cmd_ready}, 32'd0);
      chk("t3_stable",   rsp_rdata,          exq[0]);
      rsp_ready = 1'b1;
      k = 0; b = 0;
      while (k < 5 && b < 40) begin
         if (rsp_valid) begin
            chk($sformatf("t3_rdata%0d", k), rsp_rdata, exq[k]);
            k++;
         end
         tick();
         b++;
      end
      chk("t3_count",    k,                  32'd5);
      chk("t3_ready",    {31'd0, cmd_ready}, 32'd1);
      tick();
      chk("t3_idle",     {31'd0, busy},      32'd0);

      // ---- T4: 300 decode-miss reads, counter saturation, clear priority
      for (int i = 1; i <= 300; i++) begin
         send(13'h1FFC, 1'b0, 32'd0);
         b = 0;
         while (!rsp_valid && b < 10) begin
            tick();
            b++;
         end
         chk("t4_err", {31'd0, rsp_err}, 32'd1);
         if (i == 100) chk("t4_cnt100", {24'd0, err_cnt}, 32'd100);
         if (i == 255) chk("t4_cnt255", {24'd0, err_cnt}, 32'd255);
      end
      chk("t4_sat", {24'd0, err_cnt}, 32'd255);
      tick();
      send(13'h1FFC, 1'b0, 32'd0);                        // N+1
      tick();                                             // N+2: ACCESS, error on bus
      chk("t4_clr_ena", {31'd0, mem_ena}, 32'd1);
      err_clr = 1'b1;
      tick();                                             // N+3
      err_clr = 1'b0;
      chk("t4_clr_cnt", {24'd0, err_cnt}, 32'd0);
      chk("t4_clr_err", {31'd0, rsp_err}, 32'd1);
      tick(); tick();

      // ---- T5: reset during ACCESS with three entries queued
      for (int i = 0; i < 6; i++) send(13'h0040 + 13'(4 * i), 1'b0, 32'd0);
      chk("t5_in_access", {31'd0, mem_ena}, 32'd1);
      chk("t5_busy",      {31'd0, busy},    32'd1);
      rst = 1'b1;
      #1;
      chk("t5_rst_ready", {31'd0, cmd_ready}, 32'd0);
      chk("t5_rst_rsp",   {31'd0, rsp_valid}, 32'd0);
      chk("t5_rst_ena",   {31'd0, mem_ena},   32'd0);
      chk("t5_rst_addr",  {19'd0, mem_addr},  32'd0);
      chk("t5_rst_busy",  {31'd0, busy},      32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("t5_ready",     {31'd0, cmd_ready}, 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (rsp_valid || mem_ena) seen = 1'b1;
         tick();
      end
      chk("t5_no_stale",  {31'd0, seen},      32'd0);
      chk("t5_idle",      {31'd0, busy},      32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
